multicycle_ctrl: RTL

- Main control FSM for the multicycle RV32I core. It sequences instruction fetch, decode, execute, memory access and writeback over several cycles, and drives the datapath mux selects and write enables.
- Covers the same opcode set as the single-cycle decoder: lw (3), sw (35), R-type (51), B-type (99), I-type (19), jal (111) and CSR (115). Adds a memory req/ready handshake, an illegal-opcode trap and a retired-instruction counter.
- Sits between the instruction register / ALU-zero flag and the shared instruction/data memory port.

---
 rtl/ctrl_pkg.sv | 72 +++++++
 rtl/ctrl_outdec.sv | 89 ++++++++
 rtl/multicycle_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control FSM: state encodings,
// opcodes, datapath mux-select codes and the decoded control bundle.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_CSR      = 4'd11,
        S_TRAP     = 4'd12
    } state_e;

    localparam logic [6:0] OP_LW  = 7'd3;
    localparam logic [6:0] OP_SW  = 7'd35;
    localparam logic [6:0] OP_R   = 7'd51;
    localparam logic [6:0] OP_B   = 7'd99;
    localparam logic [6:0] OP_I   = 7'd19;
    localparam logic [6:0] OP_JAL = 7'd111;
    localparam logic [6:0] OP_CSR = 7'd115;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    localparam logic [1:0] MOCSR_NONE = 2'b00;
    localparam logic [1:0] MOCSR_RD   = 2'b01;

    typedef struct packed {
        logic       mem_req;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] mocsr;
        logic       illegal;
    } ctrl_out_t;

    // A store retires only on the cycle its memory access completes.
    function automatic logic is_retiring(state_e s, logic mem_ready);
        case (s)
            S_MEMWB, S_ALUWB, S_BRANCH, S_CSR: return 1'b1;
            S_MEMWRITE:                        return mem_ready;
            default:                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_outdec.sv
// Combinational state-to-control decode. Moore except irWrite/pcWrite in
// FETCH (follow memReady) and pcWrite in BRANCH (follows zero).
module ctrl_outdec
    import ctrl_pkg::*;
(
    input  state_e    state,
    input  logic      zero,
    input  logic      mem_ready,
    output ctrl_out_t ctrl
);

    always_comb begin
        // NOTE: everything defaults to 0 first so no path leaves a latch behind.
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_req    = 1'b1;
                ctrl.adr_src    = 1'b0;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALU;
                ctrl.ir_write   = mem_ready;
                ctrl.pc_write   = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                ctrl.mem_req = 1'b1;
                ctrl.adr_src = 1'b1;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_MEMDATA;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.mem_req   = 1'b1;
                ctrl.adr_src   = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_EXECR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_RS2;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = SRCA_RS1;
                ctrl.alu_src_b  = SRCB_RS2;
                ctrl.alu_op     = ALUOP_BRANCH;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_write   = zero;
            end
            S_JAL: begin
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_write   = 1'b1;
            end
            S_CSR: begin
                ctrl.mocsr      = MOCSR_RD;
                ctrl.result_src = RES_MEMDATA;
                ctrl.reg_write  = 1'b1;
            end
            S_TRAP: begin
                ctrl.illegal = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core: sequences fetch through
// writeback, handshakes with the shared memory port and counts retirements.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter bit          CSR_EN    = 1'b1,
    parameter int unsigned INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           op,
    input  logic                 zero,
    input  logic                 memReady,
    output logic                 memReq,
    output logic                 adrSrc,
    output logic                 irWrite,
    output logic                 pcWrite,
    output logic                 memWrite,
    output logic                 regWrite,
    output logic [1:0]           resultSrc,
    output logic [1:0]           aluSrcA,
    output logic [1:0]           aluSrcB,
    output logic [1:0]           aluOp,
    output logic [1:0]           mocsr,
    output logic                 illegal,
    output logic [INSTRET_W-1:0] instret
);

    state_e                state_q, state_d;
    logic [INSTRET_W-1:0]  instret_q, instret_d;
    ctrl_out_t             dec;

    always_comb begin
        state_d   = state_q;
        instret_d = instret_q;
        case (state_q)
            S_FETCH:    if (memReady) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_B:         state_d = S_BRANCH;
                    OP_JAL:       state_d = S_JAL;
                    OP_CSR:       state_d = CSR_EN ? S_CSR : S_TRAP;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (memReady) state_d = S_MEMWB;
            S_MEMWRITE: if (memReady) state_d = S_FETCH;
            S_EXECR,
            S_EXECI,
            S_JAL:      state_d = S_ALUWB;
            S_MEMWB,
            S_ALUWB,
            S_BRANCH,
            S_CSR:      state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
        if (is_retiring(state_q, memReady)) begin
            instret_d = instret_q + INSTRET_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every flop samples pre-edge values.
        if (rst) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    ctrl_outdec u_outdec (
        .state     (state_q),
        .zero      (zero),
        .mem_ready (memReady),
        .ctrl      (dec)
    );

    // Enables are masked during reset so an aborted access never writes.
    assign memReq    = dec.mem_req   & ~rst;
    assign irWrite   = dec.ir_write  & ~rst;
    assign pcWrite   = dec.pc_write  & ~rst;
    assign memWrite  = dec.mem_write & ~rst;
    assign regWrite  = dec.reg_write & ~rst;
    assign adrSrc    = dec.adr_src;
    assign resultSrc = dec.result_src;
    assign aluSrcA   = dec.alu_src_a;
    assign aluSrcB   = dec.alu_src_b;
    assign aluOp     = dec.alu_op;
    assign mocsr     = dec.mocsr;
    assign illegal   = dec.illegal;
    assign instret   = instret_q;

endmodule
